// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types and constants for the game ROM arbiter and its channel picker.
package jtframe_rom_arb_pkg;

  localparam int MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational channel picker: round-robin from a pointer, or fixed priority
// where the lowest pending index wins.
module jtframe_rr_pick
  import jtframe_rom_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] pending_i,
  input  logic [IW-1:0]       ptr_i,
  input  logic                rr_i,
  output logic [IW-1:0]       grant_o,
  output logic                any_o
);

  logic [IW-1:0] idx;

  // Pointer is always below CHANNELS, so a single subtraction wraps the sum.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= CHANNELS) s = s - CHANNELS;
    return IW'(s);
  endfunction

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = rr_i ? wrap_add(ptr_i, k) : IW'(k);
      if (!any_o && pending_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Game ROM read arbiter: per-channel single-entry cache in front of one shared
// SDRAM request port, with a three-state request/ack/data handshake.
module jtframe_rom_arb
  import jtframe_rom_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int AW       = 22,
  parameter int DW       = 32,
  parameter int BANKW    = 2,
  parameter int RR       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      downloading,
  input  logic [CHANNELS-1:0]       ch_req,
  input  logic [CHANNELS*AW-1:0]    ch_addr,
  input  logic [CHANNELS*BANKW-1:0] ch_bank,
  output logic [CHANNELS*DW-1:0]    ch_data,
  output logic [CHANNELS-1:0]       ch_ok,
  output logic                      sdram_req,
  output logic [AW-1:0]             sdram_addr,
  output logic [BANKW-1:0]          sdram_bank,
  input  logic                      sdram_ack,
  input  logic                      data_rdy,
  input  logic [DW-1:0]             data_read
);

  localparam int IW = idx_width(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("jtframe_rom_arb: CHANNELS out of range");
  end

  arb_state_e         state_q;
  logic               req_q;
  logic [AW-1:0]      addr_q;
  logic [BANKW-1:0]   bank_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      ptr_d;
  logic               stale_q;

  logic [AW-1:0]      tag_addr_q [CHANNELS];
  logic [BANKW-1:0]   tag_bank_q [CHANNELS];
  logic [DW-1:0]      data_q     [CHANNELS];
  logic [CHANNELS-1:0] valid_q;

  logic [CHANNELS-1:0] pending;
  logic [IW-1:0]       grant;
  logic                any;
  logic [AW-1:0]       gnt_addr;
  logic [BANKW-1:0]    gnt_bank;

  // Hit detection works straight off registered tags: zero-latency hits.
  always_comb begin
    ch_ok    = '0;
    ch_data  = '0;
    gnt_addr = '0;
    gnt_bank = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_ok[i] = ch_req[i] & valid_q[i]
               & (tag_addr_q[i] == ch_addr[i*AW +: AW])
               & (tag_bank_q[i] == ch_bank[i*BANKW +: BANKW]);
      ch_data[i*DW +: DW] = data_q[i];
      if (grant == IW'(i)) begin
        gnt_addr = ch_addr[i*AW +: AW];
        gnt_bank = ch_bank[i*BANKW +: BANKW];
      end
    end
  end

  assign pending = ch_req & ~ch_ok;

  jtframe_rr_pick #(
    .CHANNELS (CHANNELS),
    .IW       (IW)
  ) u_pick (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .rr_i      (RR != 0),
    .grant_o   (grant),
    .any_o     (any)
  );

  assign ptr_d = (grant == IW'(CHANNELS - 1)) ? '0 : grant + 1'b1;

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign sdram_bank = bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      bank_q  <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      stale_q <= 1'b0;
      valid_q <= '0;
      // NOTE: the cache is a handful of flops, so tags and data are reset too.
      for (int i = 0; i < CHANNELS; i++) begin
        tag_addr_q[i] <= '0;
        tag_bank_q[i] <= '0;
        data_q[i]     <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (any && !downloading) begin
            req_q   <= 1'b1;
            addr_q  <= gnt_addr;
            bank_q  <= gnt_bank;
            gidx_q  <= grant;
            ptr_q   <= ptr_d;
            stale_q <= 1'b0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          // The fetched address is stored even if the channel has moved on.
          if (data_rdy) begin
            tag_addr_q[gidx_q] <= addr_q;
            tag_bank_q[gidx_q] <= bank_q;
            data_q[gidx_q]     <= data_read;
            valid_q[gidx_q]    <= ~stale_q;
            state_q            <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // A download invalidates everything, including a fetch still in flight.
      if (downloading) begin
        valid_q <= '0;
        if (state_q != IDLE) stale_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/jtframe_rom_arb.md
JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of game ROM request channels, legal range 2..8.
REQ-002 SHALL have parameter AW, default 22, SDRAM word address width.
REQ-003 SHALL have parameter DW, default 32, read data width.
REQ-004 SHALL have parameter BANKW, default 2, SDRAM bank field width.
REQ-005 SHALL have parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 downloading  input  1  ROM download in progress; blocks issue, invalidates cache.
REQ-010 ch_req  input  CHANNELS  per-channel read request level.
REQ-011 ch_addr  input  CHANNELS*AW  per-channel address, channel i at bits [i*AW +: AW].
REQ-012 ch_bank  input  CHANNELS*BANKW  per-channel bank.
REQ-013 ch_data  output  CHANNELS*DW  per-channel last fetched data.
REQ-014 ch_ok  output  CHANNELS  channel data valid for current address.
REQ-015 sdram_req  output  1  request to SDRAM controller.
REQ-016 sdram_addr  output  AW  request address.
REQ-017 sdram_bank  output  BANKW  request bank.
REQ-018 sdram_ack  input  1  controller accepted request.
REQ-019 data_rdy  input  1  one-cycle pulse, data_read valid.
REQ-020 data_read  input  DW  read data.

Function
REQ-021 SHALL keep per channel a cache entry: tag address, tag bank, data, valid bit.
REQ-022 ch_ok[i] SHALL be high iff ch_req[i] & valid[i] & tag address == ch_addr[i] & tag bank == ch_bank[i]; registered-state compare, no added latency.
REQ-023 A channel is pending iff ch_req[i] & ~ch_ok[i]; only pending channels SHALL compete.
REQ-024 FSM states IDLE, WAIT_ACK, WAIT_RDY; reset state IDLE.
REQ-025 IDLE: if any channel pending and downloading low, SHALL grant one, register its address/bank/index, assert sdram_req next cycle, go WAIT_ACK.
REQ-026 WAIT_ACK: sdram_req, sdram_addr, sdram_bank SHALL stay stable until sdram_ack; on sdram_ack sdram_req drops next cycle, go WAIT_RDY.
REQ-027 WAIT_RDY: on data_rdy SHALL write data_read, granted address/bank into granted entry, set valid, go IDLE; ch_ok rises the cycle after data_rdy.
REQ-028 Hit latency 0 cycles; miss latency from pending to sdram_req = 1 cycle.
REQ-029 RR=1: pointer starts at 0; search from pointer upward with wrap at CHANNELS-1 -> 0; after a grant pointer = granted index + 1 mod CHANNELS.
REQ-030 RR=0: lowest pending index SHALL win every time.
REQ-031 A channel changing ch_addr mid-transaction SHALL still receive the fetched (old-address) tag; ch_ok stays low and it re-competes.
REQ-032 data_rdy in IDLE or WAIT_ACK SHALL be ignored.
REQ-033 downloading high: all valid bits cleared every cycle, no new grant; an in-flight transaction SHALL complete the handshake but its data SHALL NOT set valid.
REQ-034 data_rdy and new pending request same cycle: update entry, return IDLE; grant decided next cycle.

Reset
REQ-035 On rst: state IDLE, sdram_req 0, sdram_addr 0, sdram_bank 0, all valid 0, ch_data 0, tags 0, pointer 0; ch_ok therefore 0.
REQ-036 rst mid-transaction SHALL abandon it; a later data_rdy for it is ignored by REQ-032.

Structure
REQ-037 Shared package jtframe_rom_arb_pkg SHALL hold the FSM state enum and constant MAX_CHANNELS = 8.
REQ-038 Arbitration SHALL live in sub-module jtframe_rr_pick (inputs pending vector, pointer, RR mode; outputs grant index, any flag), purely combinational.
REQ-039 Top integration SHALL replace the single game sdram_req/sdram_addr path with this block.

Verification
REQ-040 CHANNELS=4, RR=1, ch_req=4'b1111 distinct addresses, controller ack 2 cycles after req, data_rdy 4 after ack -> grants 0,1,2,3 in order; each ch_ok rises the cycle after its data_rdy.
REQ-041 RR=0, channels 0 and 2 re-requesting new addresses continuously -> channel 0 granted every time, channel 2 only when channel 0 holds a hit.
REQ-042 Channel 1 reads addr 0x1234 data 0xCAFEBABE, then re-requests 0x1234 -> ch_ok[1] high same cycle, no sdram_req, ch_data[1]=0xCAFEBABE.
REQ-043 downloading pulsed high while WAIT_RDY -> sdram handshake completes, valid stays 0, no sdram_req until downloading low, all ch_ok low.
REQ-044 rst asserted in WAIT_ACK with sdram_req=1 -> next cycle sdram_req=0, state IDLE, all ch_ok=0; stray data_rdy afterwards changes nothing.
REQ-045 Channel 3 changes address 0x10 -> 0x20 during WAIT_RDY -> tag 0x10 stored, ch_ok[3] stays low, new request for 0x20 issued.
